mips_debug_ctrl: RTL and testbench

- Synthesizable debug/bring-up controller for the parametrised single-cycle MIPS core.
- Replaces bench-only memory preload and state dump with a host command port:
  - loads instruction memory
  - dumps register file or data memory
  - runs the core for N cycles via a clock-enable
- Sits between a host link (UART/JTAG bridge) and the core's memory/regfile debug ports; the core runs only while cpu_run=1.

---
 rtl/mips_dbg_pkg.sv | 25 ++
 rtl/dbg_out_stage.sv | 42 ++++
 rtl/mips_debug_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared encodings and default widths for the MIPS debug/bring-up controller.
package mips_dbg_pkg;

  localparam int unsigned DEF_INST_W  = 32;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_IMEM_AW = 10;
  localparam int unsigned DEF_DMEM_AW = 10;
  localparam int unsigned DEF_REG_AW  = 4;
  localparam int unsigned DEF_LEN_W   = 16;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD_IMEM = 3'd1;
  localparam logic [2:0] OP_DUMP_REGS = 3'd2;
  localparam logic [2:0] OP_DUMP_DMEM = 3'd3;
  localparam logic [2:0] OP_RUN       = 3'd4;
  localparam logic [2:0] OP_HALT      = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP,
    ST_RUN
  } state_e;

endpackage

// File: rtl/dbg_out_stage.sv
// Single-entry registered valid/ready output stage shared by register/memory dumps and PC trace.
module dbg_out_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         rd_last,
  output logic         can_load
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;

  // Refill in the same cycle the current beat is consumed to sustain one beat per cycle.
  assign can_load = !valid_q || rd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load && can_load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      last_q  <= load_last;
    end else if (rd_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign rd_last  = last_q;

endmodule

// File: rtl/mips_debug_ctrl.sv
// Host-command debug controller: IMEM load, regfile/DMEM dump, counted/free run of the core.
// Optional PC trace during RUN is enabled by defining MIPS_DBG_TRACE_EN.
module mips_debug_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned INST_W  = DEF_INST_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned IMEM_AW = DEF_IMEM_AW,
  parameter int unsigned DMEM_AW = DEF_DMEM_AW,
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned LEN_W   = DEF_LEN_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [INST_W-1:0]  wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [INST_W-1:0]  rd_data,
  output logic               rd_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [INST_W-1:0]  imem_wdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [REG_AW-1:0]  reg_addr,
  input  logic [DATA_W-1:0]  reg_rdata,
  input  logic [IMEM_AW-1:0] cpu_pc,
  output logic               cpu_run,
  output logic               busy,
  output logic               err
);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               src_dmem_q, src_dmem_d;
  logic               free_q, free_d;
  logic               err_q, err_d;
`ifdef MIPS_DBG_TRACE_EN
  logic               done_q, done_d;
`endif

  logic               idle_cmd;
  logic [IMEM_AW-1:0] rd_ptr;
  logic               rd_src_dmem;
  logic [DATA_W-1:0]  src_data;
  logic               out_load;
  logic [INST_W-1:0]  out_data;
  logic               out_last;
  logic               stage_free;
  logic               exec;
  logic               finish;

  // The first dump beat is read straight from the command so it is valid one cycle after accept.
  assign idle_cmd    = (state_q == ST_IDLE) && cmd_valid;
  assign rd_ptr      = idle_cmd ? cmd_addr : ptr_q;
  assign rd_src_dmem = idle_cmd ? (cmd_op == OP_DUMP_DMEM) : src_dmem_q;
  assign src_data    = rd_src_dmem ? dmem_rdata : reg_rdata;
  assign reg_addr    = rd_ptr[REG_AW-1:0];
  assign dmem_addr   = rd_ptr[DMEM_AW-1:0];
  assign imem_addr   = ptr_q;

`ifndef MIPS_DBG_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^cpu_pc;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    src_dmem_d = src_dmem_q;
    free_d     = free_q;
    err_d      = err_q;
`ifdef MIPS_DBG_TRACE_EN
    done_d     = done_q;
`endif
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = '0;
    out_load   = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    exec       = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD_IMEM: begin
              if (cmd_len != '0) begin
                state_d = ST_LOAD;
                ptr_d   = cmd_addr;
                cnt_d   = cmd_len;
              end
            end
            OP_DUMP_REGS, OP_DUMP_DMEM: begin
              if (cmd_len != '0) begin
                state_d    = ST_DUMP;
                src_dmem_d = rd_src_dmem;
                out_load   = 1'b1;
                out_data   = INST_W'(src_data);
                out_last   = (cmd_len == LEN_W'(1));
                ptr_d      = cmd_addr + IMEM_AW'(1);
                cnt_d      = cmd_len - LEN_W'(1);
              end
            end
            OP_RUN: begin
              state_d = ST_RUN;
              cnt_d   = cmd_len;
              free_d  = (cmd_len == '0);
`ifdef MIPS_DBG_TRACE_EN
              done_d  = 1'b0;
`endif
            end
            OP_NOP, OP_HALT: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          imem_we    = 1'b1;
          imem_wdata = wr_data;
          ptr_d      = ptr_q + IMEM_AW'(1);
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_DUMP: begin
        if (cnt_q != '0 && stage_free) begin
          out_load = 1'b1;
          out_data = INST_W'(src_data);
          out_last = (cnt_q == LEN_W'(1));
          ptr_d    = ptr_q + IMEM_AW'(1);
          cnt_d    = cnt_q - LEN_W'(1);
        end
        if (rd_valid && rd_ready && rd_last) state_d = ST_IDLE;
      end
      ST_RUN: begin
        cmd_ready = 1'b1;
`ifdef MIPS_DBG_TRACE_EN
        // A pending unaccepted trace beat freezes the core; frozen cycles are not counted.
        exec = !done_q && stage_free;
        if (exec) begin
          out_load = 1'b1;
          out_data = INST_W'(cpu_pc);
        end
`else
        exec = 1'b1;
`endif
        if (exec && !free_q) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) finish = 1'b1;
        end
        if (cmd_valid) begin
          if (cmd_op == OP_HALT) finish = 1'b1;
          else err_d = 1'b1;
        end
        if (finish) cnt_d = '0;
`ifdef MIPS_DBG_TRACE_EN
        if (finish) done_d = 1'b1;
        if (done_q && stage_free) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
`else
        if (finish) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      src_dmem_q <= 1'b0;
      free_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MIPS_DBG_TRACE_EN
      done_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      src_dmem_q <= src_dmem_d;
      free_q     <= free_d;
      err_q      <= err_d;
`ifdef MIPS_DBG_TRACE_EN
      done_q     <= done_d;
`endif
    end
  end

  dbg_out_stage #(
    .W(INST_W)
  ) u_out (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (out_load),
    .load_data(out_data),
    .load_last(out_last),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .can_load (stage_free)
  );

  assign cpu_run = exec;
  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: command table plus scoreboarded load/dump/run sequences.
module tb_mips_debug_ctrl;
  import mips_dbg_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [9:0]  cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [9:0]  dmem_addr;
  logic [15:0] dmem_rdata;
  logic [3:0]  reg_addr;
  logic [15:0] reg_rdata;
  logic [9:0]  cpu_pc;
  logic        cpu_run;
  logic        busy;
  logic        err;

  always #5 clock = ~clock;

  mips_debug_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .dmem_addr (dmem_addr),
    .dmem_rdata(dmem_rdata),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .cpu_pc    (cpu_pc),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .err       (err)
  );

  logic [15:0] reg_mem [16];
  logic [15:0] dmem_mem [1024];
  assign reg_rdata  = reg_mem[reg_addr];
  assign dmem_rdata = dmem_mem[dmem_addr];

  // Core PC model: advances only on enabled cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cpu_pc <= 10'h010;
    else if (cpu_run) cpu_pc <= cpu_pc + 10'd1;
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [9:0]  addr;
    logic [15:0] len;
    logic        exp_err;
    logic        exp_busy;
    logic        exp_busy2;
  } vec_t;

  beat_t rd_q[$];
  wr_t   imem_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    run_cycles = 0;
  logic  skip_beats = 1'b0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic  prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard / protocol monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (cpu_run) run_cycles++;
      if (imem_we) begin
        if (imem_q.size() == 0) begin
          check("unexpected_imem_we", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = imem_q.pop_front();
          check("imem_addr", 32'(imem_addr), 32'(w.addr));
          check("imem_wdata", imem_wdata, w.data);
        end
      end
      if (prev_stall) begin
        check("hold_valid", 32'(rd_valid), 32'd1);
        check("hold_data", rd_data, prev_data);
        check("hold_last", 32'(rd_last), 32'(prev_last));
      end
      if (rd_valid && rd_ready && !skip_beats) begin
        if (rd_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          beat_t b;
          b = rd_q.pop_front();
          check("rd_data", rd_data, b.data);
          check("rd_last", 32'(rd_last), 32'(b.last));
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b1;
    rd_q.delete();
    imem_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [9:0] addr, input logic [15:0] len);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    while (!cmd_ready && t < 100) begin
      step();
      t++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 200) begin
      step();
      t++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int c;
    logic [31:0] words [4];

    for (int i = 0; i < 16; i++) reg_mem[i] = 16'(i * 3);
    for (int i = 0; i < 1024; i++) dmem_mem[i] = 16'hA000 ^ 16'(i * 37);
    words[0] = 32'h1111_AAAA;
    words[1] = 32'h2222_BBBB;
    words[2] = 32'h3333_CCCC;
    words[3] = 32'h4444_DDDD;

    vecs[0] = '{"nop",        OP_NOP,       10'd0, 16'd5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"halt_idle",  OP_HALT,      10'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"load_len0",  OP_LOAD_IMEM, 10'd7, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"dregs_len0", OP_DUMP_REGS, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"ddmem_len0", OP_DUMP_DMEM, 10'd3, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"op6",        3'd6,         10'd0, 16'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"op7",        3'd7,         10'd0, 16'd2, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"run_len3",   OP_RUN,       10'd0, 16'd3, 1'b0, 1'b1, 1'b1};

    // Reset values, sampled while reset is held.
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);

    // Command table: zero-length, idle-only and illegal ops.
`ifdef MIPS_DBG_TRACE_EN
    skip_beats = 1'b1;
`endif
    for (int i = 0; i < 8; i++) begin
      do_reset();
      wr_valid = 1'b1;
      wr_data  = 32'hDEAD_BEEF;
      send_cmd(vecs[i].op, vecs[i].addr, vecs[i].len);
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].exp_busy));
      step();
      step();
      check({vecs[i].name, "_busy2"}, 32'(busy), 32'(vecs[i].exp_busy2));
      check({vecs[i].name, "_rd_valid"}, 32'(rd_valid && !skip_beats), 32'd0);
      wr_valid = 1'b0;
    end
    skip_beats = 1'b0;

    // LOAD across the address wrap with gaps between words.
    do_reset();
    imem_q.push_back('{10'h3FE, words[0]});
    imem_q.push_back('{10'h3FF, words[1]});
    imem_q.push_back('{10'h000, words[2]});
    imem_q.push_back('{10'h001, words[3]});
    send_cmd(OP_LOAD_IMEM, 10'h3FE, 16'd4);
    check("load_wr_ready", 32'(wr_ready), 32'd1);
    check("load_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) begin
        wr_valid = 1'b0;
        step();
      end
      check("load_busy_mid", 32'(busy), 32'd1);
      wr_valid = 1'b1;
      wr_data  = words[i];
      step();
      wr_valid = 1'b0;
    end
    check("load_busy_after", 32'(busy), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 32'hBAD0_BAD0;
    repeat (3) step();
    wr_valid = 1'b0;
    check("load_all_written", 32'(imem_q.size()), 32'd0);

    // DUMP_REGS at full throughput.
    do_reset();
    for (int i = 0; i < 16; i++) rd_q.push_back('{32'(i * 3), i == 15});
    send_cmd(OP_DUMP_REGS, 10'd0, 16'd16);
    check("dregs_first_valid", 32'(rd_valid), 32'd1);
    c = 0;
    while (rd_q.size() != 0 && c < 100) begin
      step();
      c++;
    end
    check("dregs_cycles", 32'(c), 32'd16);
    check("dregs_busy_after", 32'(busy), 32'd0);

    // DUMP_DMEM with back-pressure toggling.
    do_reset();
    rd_ready = 1'b0;
    for (int i = 5; i < 8; i++) rd_q.push_back('{32'(dmem_mem[i]), i == 7});
    send_cmd(OP_DUMP_DMEM, 10'd5, 16'd3);
    c = 0;
    while (rd_q.size() != 0 && c < 100) begin
      step();
      rd_ready = ~rd_ready;
      c++;
    end
    check("ddmem_drained", 32'(rd_q.size()), 32'd0);
    check("ddmem_busy_after", 32'(busy), 32'd0);
    rd_ready = 1'b1;

    // Counted and free-running RUN, HALT and illegal op during RUN.
    do_reset();
`ifdef MIPS_DBG_TRACE_EN
    skip_beats = 1'b1;
`endif
    run_cycles = 0;
    send_cmd(OP_RUN, 10'd0, 16'd7);
    wait_idle("run7_done");
    check("run7_cycles", 32'(run_cycles), 32'd7);
    run_cycles = 0;
    send_cmd(OP_RUN, 10'd0, 16'd0);
    repeat (20) step();
    check("free_running", 32'(cpu_run), 32'd1);
    send_cmd(OP_HALT, 10'd0, 16'd0);
    check("halt_cpu_run", 32'(cpu_run), 32'd0);
    check("halt_err", 32'(err), 32'd0);
    check("free_cycles", 32'(run_cycles), 32'd21);
    wait_idle("halt_idle");
    send_cmd(OP_RUN, 10'd0, 16'd0);
    send_cmd(OP_DUMP_REGS, 10'd0, 16'd4);
    check("run_illegal_err", 32'(err), 32'd1);
    check("run_illegal_cpu_run", 32'(cpu_run), 32'd1);
    check("run_illegal_busy", 32'(busy), 32'd1);
    send_cmd(OP_HALT, 10'd0, 16'd0);
    check("halt2_cpu_run", 32'(cpu_run), 32'd0);
    wait_idle("halt2_idle");
    skip_beats = 1'b0;

    // Asynchronous reset in the middle of a dump.
    do_reset();
    for (int i = 0; i < 8; i++) rd_q.push_back('{32'(i * 3), i == 7});
    send_cmd(OP_DUMP_REGS, 10'd0, 16'd8);
    c = 0;
    while (rd_q.size() > 6 && c < 100) begin
      step();
      c++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_data", rd_data, 32'd0);
    check("arst_rd_last", 32'(rd_last), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cpu_run", 32'(cpu_run), 32'd0);

`ifdef MIPS_DBG_TRACE_EN
    // PC trace with two stalled cycles.
    do_reset();
    run_cycles = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd_q.push_back('{32'(10'h010 + 10'(i)), 1'b0});
    send_cmd(OP_RUN, 10'd0, 16'd3);
    step();
    step();
    rd_ready = 1'b1;
    wait_idle("trace_done");
    check("trace_cycles", 32'(run_cycles), 32'd3);
    check("trace_beats", 32'(rd_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
